// File: rtl/parking_payment.sv
// Parking exit payment controller: takes a use-time fee, collects coins, returns change
// or refunds on cancel/timeout, then holds the exit gate open for a fixed number of cycles.
module parking_payment #(
    parameter int unsigned RATE           = 1,
    parameter int unsigned GATE_CYCLES    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fee_valid_i,
    input  logic [10:0] fee_i,
    input  logic [3:0]  slot_i,
    input  logic        coin_valid_i,
    input  logic [1:0]  coin_sel_i,
    input  logic        cancel_i,
    output logic        fee_ready_o,
    output logic [11:0] remaining_o,
    output logic        change_valid_o,
    output logic [11:0] change_o,
    output logic        refund_o,
    output logic        coin_reject_o,
    output logic        done_o,
    output logic [3:0]  paid_slot_o,
    output logic        gate_open_o
);

    localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StCollect, StChange, StGate} state_e;

    state_e        state_q, state_d;
    logic [11:0]   due_q, due_d;
    logic [12:0]   paid_q, paid_d;
    logic [3:0]    slot_q, slot_d;
    logic [TW-1:0] to_q, to_d;
    logic [GW-1:0] gate_cnt_q, gate_cnt_d;
    logic          fee_ready_q, fee_ready_d;
    logic [11:0]   remaining_q, remaining_d;
    logic          change_valid_q, change_valid_d;
    logic [11:0]   change_q, change_d;
    logic          refund_q, refund_d;
    logic          coin_reject_q, coin_reject_d;
    logic          done_q, done_d;
    logic [3:0]    paid_slot_q, paid_slot_d;
    logic          gate_open_q, gate_open_d;

    logic [42:0] prod;
    logic [11:0] due_in;
    logic [3:0]  coin_val;
    logic [13:0] paid_sum;
    logic [12:0] paid_new;
    logic        timeout;

    assign prod   = 43'(fee_i) * 43'(RATE);
    assign due_in = (prod > 43'd4095) ? 12'hFFF : prod[11:0];

    always_comb begin
        coin_val = 4'd1;
        unique case (coin_sel_i)
            2'd0: coin_val = 4'd1;
            2'd1: coin_val = 4'd2;
            2'd2: coin_val = 4'd5;
            2'd3: coin_val = 4'd10;
        endcase
    end

    // Accumulator saturates at 13 bits; the coin of this cycle is already included.
    assign paid_sum = 14'(paid_q) + 14'(coin_valid_i ? coin_val : 4'd0);
    assign paid_new = paid_sum[13] ? 13'h1FFF : paid_sum[12:0];
    assign timeout  = !coin_valid_i && (to_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d        = state_q;
        due_d          = due_q;
        paid_d         = paid_q;
        slot_d         = slot_q;
        to_d           = to_q;
        gate_cnt_d     = gate_cnt_q;
        change_d       = change_q;
        change_valid_d = 1'b0;
        refund_d       = 1'b0;
        coin_reject_d  = 1'b0;
        done_d         = 1'b0;
        paid_slot_d    = paid_slot_q;

        case (state_q)
            StIdle: begin
                coin_reject_d = coin_valid_i;
                if (fee_valid_i) begin
                    if (due_in == 12'd0) begin
                        state_d     = StGate;
                        gate_cnt_d  = '0;
                        done_d      = 1'b1;
                        paid_slot_d = slot_i;
                    end else begin
                        state_d = StCollect;
                        due_d   = due_in;
                        paid_d  = '0;
                        to_d    = '0;
                        slot_d  = slot_i;
                    end
                end
            end
            StCollect: begin
                // Completion takes precedence over cancel and timeout.
                if (paid_new >= {1'b0, due_q}) begin
                    state_d        = StChange;
                    paid_d         = paid_new;
                    change_d       = 12'(paid_new - {1'b0, due_q});
                    change_valid_d = 1'b1;
                    done_d         = 1'b1;
                    paid_slot_d    = slot_q;
                end else if (cancel_i || timeout) begin
                    state_d        = StIdle;
                    change_d       = paid_new[11:0];
                    change_valid_d = 1'b1;
                    refund_d       = 1'b1;
                    paid_d         = '0;
                    to_d           = '0;
                end else begin
                    paid_d = paid_new;
                    to_d   = coin_valid_i ? '0 : to_q + TW'(1);
                end
            end
            StChange: begin
                coin_reject_d = coin_valid_i;
                state_d       = StGate;
                gate_cnt_d    = '0;
            end
            StGate: begin
                coin_reject_d = coin_valid_i;
                if (gate_cnt_q == GW'(GATE_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    gate_cnt_d = gate_cnt_q + GW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        fee_ready_d = (state_d == StIdle);
        gate_open_d = (state_d == StGate);
        remaining_d = (state_d == StCollect) ? (due_d - paid_d[11:0]) : 12'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            due_q          <= '0;
            paid_q         <= '0;
            slot_q         <= '0;
            to_q           <= '0;
            gate_cnt_q     <= '0;
            fee_ready_q    <= 1'b1;
            remaining_q    <= '0;
            change_valid_q <= 1'b0;
            change_q       <= '0;
            refund_q       <= 1'b0;
            coin_reject_q  <= 1'b0;
            done_q         <= 1'b0;
            paid_slot_q    <= '0;
            gate_open_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            due_q          <= due_d;
            paid_q         <= paid_d;
            slot_q         <= slot_d;
            to_q           <= to_d;
            gate_cnt_q     <= gate_cnt_d;
            fee_ready_q    <= fee_ready_d;
            remaining_q    <= remaining_d;
            change_valid_q <= change_valid_d;
            change_q       <= change_d;
            refund_q       <= refund_d;
            coin_reject_q  <= coin_reject_d;
            done_q         <= done_d;
            paid_slot_q    <= paid_slot_d;
            gate_open_q    <= gate_open_d;
        end
    end

    assign fee_ready_o    = fee_ready_q;
    assign remaining_o    = remaining_q;
    assign change_valid_o = change_valid_q;
    assign change_o       = change_q;
    assign refund_o       = refund_q;
    assign coin_reject_o  = coin_reject_q;
    assign done_o         = done_q;
    assign paid_slot_o    = paid_slot_q;
    assign gate_open_o    = gate_open_q;

endmodule

// File: tb/tb_parking_payment.sv
// Scoreboard bench for parking_payment: directed scenarios plus random traffic against a
// session-level payment model; a separate monitor matches strobes to expected events.
module tb_parking_payment;

    localparam int unsigned RATE           = 1;
    localparam int unsigned GATE_CYCLES    = 8;
    localparam int unsigned TIMEOUT_CYCLES = 1000;

    localparam int MIdle    = 0;
    localparam int MCollect = 1;
    localparam int MChange  = 2;
    localparam int MGate    = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fee_valid_i = 1'b0;
    logic [10:0] fee_i = '0;
    logic [3:0]  slot_i = '0;
    logic        coin_valid_i = 1'b0;
    logic [1:0]  coin_sel_i = '0;
    logic        cancel_i = 1'b0;
    logic        fee_ready_o;
    logic [11:0] remaining_o;
    logic        change_valid_o;
    logic [11:0] change_o;
    logic        refund_o;
    logic        coin_reject_o;
    logic        done_o;
    logic [3:0]  paid_slot_o;
    logic        gate_open_o;

    parking_payment #(
        .RATE          (RATE),
        .GATE_CYCLES   (GATE_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fee_valid_i   (fee_valid_i),
        .fee_i         (fee_i),
        .slot_i        (slot_i),
        .coin_valid_i  (coin_valid_i),
        .coin_sel_i    (coin_sel_i),
        .cancel_i      (cancel_i),
        .fee_ready_o   (fee_ready_o),
        .remaining_o   (remaining_o),
        .change_valid_o(change_valid_o),
        .change_o      (change_o),
        .refund_o      (refund_o),
        .coin_reject_o (coin_reject_o),
        .done_o        (done_o),
        .paid_slot_o   (paid_slot_o),
        .gate_open_o   (gate_open_o)
    );

    always #5 clk = ~clk;

    typedef struct {int tag; int amt; bit refund;} chg_t;
    typedef struct {int tag; int slot;} done_t;

    chg_t  chg_q[$];
    done_t done_q[$];
    int    rej_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int edge_cnt = 0;
    int coin_tab[4] = '{1, 2, 5, 10};

    // Session-level model of the payment flow.
    int m_mode = MIdle;
    int m_due, m_paid, m_idle, m_slot, m_gate_left;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    task automatic model_step(input bit fv, input int fee, input int slot, input bit cv,
                              input int sel, input bit cn);
        int tag;
        int p;
        int due;
        tag = edge_cnt + 1;
        case (m_mode)
            MIdle: begin
                if (cv) rej_q.push_back(tag);
                if (fv) begin
                    due = fee * RATE;
                    if (due > 4095) due = 4095;
                    if (due == 0) begin
                        done_q.push_back(done_t'{tag, slot});
                        m_mode      = MGate;
                        m_gate_left = GATE_CYCLES;
                    end else begin
                        m_mode = MCollect;
                        m_due  = due;
                        m_paid = 0;
                        m_idle = 0;
                        m_slot = slot;
                    end
                end
            end
            MCollect: begin
                p = m_paid + (cv ? coin_tab[sel] : 0);
                if (p > 8191) p = 8191;
                if (p >= m_due) begin
                    chg_q.push_back(chg_t'{tag, p - m_due, 1'b0});
                    done_q.push_back(done_t'{tag, m_slot});
                    m_mode = MChange;
                end else begin
                    m_idle = cv ? 0 : m_idle + 1;
                    m_paid = p;
                    if (cn || m_idle >= TIMEOUT_CYCLES) begin
                        chg_q.push_back(chg_t'{tag, p, 1'b1});
                        m_mode = MIdle;
                    end
                end
            end
            MChange: begin
                if (cv) rej_q.push_back(tag);
                m_mode      = MGate;
                m_gate_left = GATE_CYCLES;
            end
            default: begin
                if (cv) rej_q.push_back(tag);
                m_gate_left--;
                if (m_gate_left == 0) m_mode = MIdle;
            end
        endcase
    endtask

    // Called at a falling edge: check levels from the last rising edge, drive, predict.
    task automatic cycle(input bit fv, input int fee, input int slot, input bit cv,
                         input int sel, input bit cn);
        check("fee_ready", int'(fee_ready_o), int'(m_mode == MIdle));
        check("remaining", int'(remaining_o), (m_mode == MCollect) ? m_due - m_paid : 0);
        check("gate_open", int'(gate_open_o), int'(m_mode == MGate));
        fee_valid_i  = fv;
        fee_i        = 11'(fee);
        slot_i       = 4'(slot);
        coin_valid_i = cv;
        coin_sel_i   = 2'(sel);
        cancel_i     = cn;
        model_step(fv, fee, slot, cv, sel, cn);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0, 0, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check("rst fee_ready", int'(fee_ready_o), 1);
        check("rst remaining", int'(remaining_o), 0);
        check("rst change", int'(change_o), 0);
        check("rst change_valid", int'(change_valid_o), 0);
        check("rst refund", int'(refund_o), 0);
        check("rst coin_reject", int'(coin_reject_o), 0);
        check("rst done", int'(done_o), 0);
        check("rst paid_slot", int'(paid_slot_o), 0);
        check("rst gate_open", int'(gate_open_o), 0);
    endtask

    task automatic async_reset();
        fee_valid_i  = 1'b0;
        coin_valid_i = 1'b0;
        cancel_i     = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        chg_q.delete();
        done_q.delete();
        rej_q.delete();
        m_mode = MIdle;
        m_paid = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every strobe must match the head of its queue on the predicted edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (chg_q.size() > 0 && chg_q[0].tag == edge_cnt) begin
                chg_t ce;
                ce = chg_q.pop_front();
                check("change_valid strobe", int'(change_valid_o), 1);
                check("change amount", int'(change_o), ce.amt);
                check("refund flag", int'(refund_o), int'(ce.refund));
            end else if (change_valid_o) begin
                check("change_valid strobe", int'(change_valid_o), 0);
            end
            if (done_q.size() > 0 && done_q[0].tag == edge_cnt) begin
                done_t de;
                de = done_q.pop_front();
                check("done strobe", int'(done_o), 1);
                check("paid_slot", int'(paid_slot_o), de.slot);
            end else if (done_o) begin
                check("done strobe", int'(done_o), 0);
            end
            if (rej_q.size() > 0 && rej_q[0] == edge_cnt) begin
                void'(rej_q.pop_front());
                check("coin_reject strobe", int'(coin_reject_o), 1);
            end else if (coin_reject_o) begin
                check("coin_reject strobe", int'(coin_reject_o), 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit fv, cv, cn;
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // fee 7, slot 3, coins 5 then 2: exact payment.
        cycle(1'b1, 7, 3, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 0, 1'b1, 2, 1'b0);
        cycle(1'b0, 0, 0, 1'b1, 1, 1'b0);
        idle_cycles(12);

        // fee 4, coin 10: change 6.
        cycle(1'b1, 4, 5, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 0, 1'b1, 3, 1'b0);
        idle_cycles(12);

        // fee 20, coin 5, cancel with simultaneous coin 2: refund 7.
        cycle(1'b1, 20, 2, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 0, 1'b1, 2, 1'b0);
        cycle(1'b0, 0, 0, 1'b1, 1, 1'b1);
        idle_cycles(3);

        // fee 0: immediate gate; coin during gate rejected; cancel in gate ignored.
        cycle(1'b1, 0, 6, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 0, 1'b1, 0, 1'b0);
        cycle(1'b0, 0, 0, 1'b0, 0, 1'b1);
        idle_cycles(8);

        // Completing coin beats a simultaneous cancel.
        cycle(1'b1, 3, 1, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 0, 1'b1, 1, 1'b0);
        cycle(1'b0, 0, 0, 1'b1, 0, 1'b1);
        idle_cycles(11);

        // fee 9 with no coins: timeout refund of 0; then fee_valid during gate ignored.
        cycle(1'b1, 9, 4, 1'b0, 0, 1'b0);
        idle_cycles(TIMEOUT_CYCLES + 2);
        cycle(1'b1, 0, 2, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 0, 1'b0, 0, 1'b0);
        cycle(1'b1, 5, 3, 1'b0, 0, 1'b0);
        idle_cycles(9);

        // Async reset mid-collect with paid 5, then quiet cycles.
        cycle(1'b1, 8, 5, 1'b0, 0, 1'b0);
        cycle(1'b0, 0, 0, 1'b1, 2, 1'b0);
        async_reset();
        idle_cycles(5);

        for (int i = 0; i < 4000; i++) begin
            fv = (m_mode == MIdle) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            cv = ($urandom_range(0, 1) == 1);
            cn = ($urandom_range(0, 29) == 0);
            cycle(fv, int'($urandom_range(0, 40)), int'($urandom_range(1, 6)), cv,
                  int'($urandom_range(0, 3)), cn);
        end
        idle_cycles(12);

        check("pending change events", chg_q.size(), 0);
        check("pending done events", done_q.size(), 0);
        check("pending reject events", rej_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/parking_payment.md
PARKING_PAYMENT -- requirements
Module: parking_payment

Interface
REQ-001 Parameter: RATE, 1, multiplier from check-out use-time to amount due.
REQ-002 Parameter: GATE_CYCLES, 8, clock cycles the exit gate is held open (minimum 1).
REQ-003 Parameter: TIMEOUT_CYCLES, 1000, idle cycles in COLLECT before auto-cancel (minimum 1).
REQ-004 Port: clk  in  1  sole clock; all state changes on rising edge.
REQ-005 Port: rst_n  in  1  asynchronous active-low reset.
REQ-006 Port: fee_valid  in  1  one-cycle strobe; fee and slot valid this cycle.
REQ-007 Port: fee  in  11  use-time from check-out (same units as the check-in timer).
REQ-008 Port: slot  in  4  parking slot number, 1..6.
REQ-009 Port: coin_valid  in  1  one-cycle strobe per inserted coin.
REQ-010 Port: coin_sel  in  2  denomination: 0=1, 1=2, 2=5, 3=10.
REQ-011 Port: cancel  in  1  driver abort request, level sampled each cycle.
REQ-012 Port: fee_ready  out  1  high only in IDLE; a fee_valid is accepted only when fee_ready=1.
REQ-013 Port: remaining  out  12  amount still owed; 0 outside COLLECT.
REQ-014 Port: change_valid  out  1  one-cycle strobe; change holds the amount to return.
REQ-015 Port: change  out  12  change or refund amount; holds its last value between strobes.
REQ-016 Port: refund  out  1  qualifies change_valid: 1 = cancel/timeout refund, 0 = normal change.
REQ-017 Port: coin_reject  out  1  one-cycle strobe for a coin offered outside COLLECT.
REQ-018 Port: done  out  1  one-cycle strobe when payment completes.
REQ-019 Port: paid_slot  out  4  slot of the last completed payment.
REQ-020 Port: gate_open  out  1  exit gate drive.

Function
REQ-021 FSM states: IDLE, COLLECT, CHANGE, GATE; registered Moore outputs except the strobes, which are registered one-cycle pulses.
REQ-022 Due computation: due = fee*RATE in 12 bits, saturating at 4095.
REQ-023 IDLE + fee_valid with due=0 -> GATE next cycle; done pulses and paid_slot=slot on that same edge; no change_valid.
REQ-024 IDLE + fee_valid with due>0 -> COLLECT; latch due and slot; paid=0; timeout counter=0.
REQ-025 COLLECT coin accounting: each coin_valid adds its value to paid (13-bit accumulator, saturating); remaining = due - paid when paid<due, else 0.
REQ-026 COLLECT completion: on the edge where paid (including the current coin) >= due -> CHANGE; change = paid - due.
REQ-027 CHANGE: lasts exactly one cycle; change_valid=1, refund=0, done=1, paid_slot=latched slot; -> GATE.
REQ-028 Cancel in COLLECT: cancel=1 -> IDLE; change = paid (including a coin arriving in the same cycle); change_valid=1 and refund=1 on the same edge; no done, no gate.
REQ-029 Precedence: a coin that completes payment in the same cycle as cancel wins (normal completion; cancel ignored).
REQ-030 Timeout: in COLLECT, the counter increments each cycle without coin_valid and clears on coin_valid; at TIMEOUT_CYCLES it behaves exactly as cancel, with refund=1 even when paid=0.
REQ-031 GATE: gate_open=1 for exactly GATE_CYCLES cycles, then IDLE; cancel is ignored in GATE.
REQ-032 Ignored/rejected inputs: fee_valid is ignored when not IDLE; coin_valid in IDLE, CHANGE or GATE gives coin_reject the next cycle and is not counted.
REQ-033 Cancel outside COLLECT has no effect.

Reset
REQ-034 rst_n=0 immediately forces the following, independent of clk, including mid-COLLECT with paid>0 (no refund strobe is issued): state=IDLE, fee_ready=1, remaining=0, change=0, change_valid=0, refund=0, coin_reject=0, done=0, paid_slot=0, gate_open=0, paid=0, counters=0.
REQ-035 After rst_n deasserts, the first rising edge is a normal IDLE cycle.

Verification
REQ-036 Scenario: fee=7, RATE=1, slot=3; coins 5,2 -> remaining 7,2,0; change_valid with change=0, refund=0; done, paid_slot=3; gate_open for 8 cycles.
REQ-037 Scenario: fee=4, coin 10 -> CHANGE with change=6; done; GATE; back to IDLE with fee_ready=1 after 8 gate cycles.
REQ-038 Scenario: fee=20, coin 5, then cancel with a simultaneous coin 2 -> change=7, refund=1; no done; gate_open stays 0.
REQ-039 Scenario: fee=0 -> done on the acceptance edge, no change_valid, gate_open 8 cycles; a coin during GATE gives coin_reject=1.
REQ-040 Scenario: fee=9, no coins for TIMEOUT_CYCLES -> change=0, refund=1, IDLE; a fee_valid during GATE is ignored.
REQ-041 Scenario: rst_n low mid-COLLECT with paid=5 -> all outputs at reset values asynchronously; no strobes after release.
